// File: rtl/spare_allocation_scheduler.sv
// Search sequencer for the spare allocation analyzer. It walks the pivot
// row/column assignments in ascending order and stops at the first one whose
// analyzer result covers every valid non-pivot fault.
module spare_allocation_scheduler #(
    parameter int PCAM    = 8,
    parameter int NPCAM   = 30,
    parameter int RSPARE  = 4,
    parameter int CSPARE  = 4,
    parameter int ANA_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [PCAM-1:0]   pivot_valid_i,
    input  logic [NPCAM-1:0]  np_valid_i,
    input  logic [NPCAM-1:0]  np_cover_i,
    output logic [PCAM-1:0]   dsss_o,
    output logic [RSPARE-1:0] rlss_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              repair_ok_o,
    output logic [PCAM-1:0]   sol_dsss_o,
    output logic [RSPARE-1:0] sol_rlss_o
);

    localparam int CW = $clog2(PCAM + 1);
    localparam int WW = $clog2(ANA_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PCAM-1:0]   cand_q, cand_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [PCAM-1:0]   pv_q, pv_d;
    logic [NPCAM-1:0]  npv_q, npv_d;
    logic [PCAM-1:0]   dsss_q, dsss_d;
    logic [RSPARE-1:0] rlss_q, rlss_d;
    logic              repair_ok_q, repair_ok_d;
    logic [PCAM-1:0]   sol_dsss_q, sol_dsss_d;
    logic [RSPARE-1:0] sol_rlss_q, sol_rlss_d;

    logic [CW-1:0]     nrow;
    logic [CW-1:0]     npiv;
    logic              cand_legal;
    logic              cand_last;
    logic              covered;
    logic [RSPARE-1:0] rlss_cand;

    function automatic logic [CW-1:0] popcnt(input logic [PCAM-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < PCAM; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    assign nrow = popcnt(cand_q);
    assign npiv = popcnt(pv_q);

    // A candidate may only place valid pivots, must fit in the row spares,
    // and the pivots left for columns must fit in the column spares.
    assign cand_legal = ((cand_q & ~pv_q) == '0) &&
                        (int'(nrow) <= RSPARE) &&
                        (int'(npiv) <= int'(nrow) + CSPARE);
    assign cand_last  = &cand_q;
    // Invalid non-pivot entries count as covered.
    assign covered    = &(np_cover_i | ~npv_q);

    // Thermometer code: the lowest nrow row-spare slots are enabled.
    genvar gi;
    generate
        for (gi = 0; gi < RSPARE; gi++) begin : g_rlss
            assign rlss_cand[gi] = (int'(nrow) > gi);
        end
    endgenerate

    // Next-state and datapath decisions for the search.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        wait_d      = wait_q;
        pv_d        = pv_q;
        npv_d       = npv_q;
        dsss_d      = dsss_q;
        rlss_d      = rlss_q;
        repair_ok_d = repair_ok_q;
        sol_dsss_d  = sol_dsss_q;
        sol_rlss_d  = sol_rlss_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    pv_d    = pivot_valid_i;
                    npv_d   = np_valid_i;
                    cand_d  = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cand_legal) begin
                    dsss_d  = cand_q;
                    rlss_d  = rlss_cand;
                    wait_d  = WW'(ANA_LAT);
                    state_d = S_APPLY;
                end else if (cand_last) begin
                    repair_ok_d = 1'b0;
                    dsss_d      = '0;
                    rlss_d      = '0;
                    state_d     = S_DONE;
                end else begin
                    cand_d = cand_q + 1'b1;
                end
            end
            S_APPLY: begin
                if (wait_q == WW'(1)) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_CHECK: begin
                if (covered) begin
                    sol_dsss_d  = cand_q;
                    sol_rlss_d  = rlss_q;
                    repair_ok_d = 1'b1;
                    dsss_d      = '0;
                    rlss_d      = '0;
                    state_d     = S_DONE;
                end else if (cand_last) begin
                    repair_ok_d = 1'b0;
                    dsss_d      = '0;
                    rlss_d      = '0;
                    state_d     = S_DONE;
                end else begin
                    cand_d  = cand_q + 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops the search without touching the last reported result.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            dsss_d      = '0;
            rlss_d      = '0;
            repair_ok_d = repair_ok_q;
            sol_dsss_d  = sol_dsss_q;
            sol_rlss_d  = sol_rlss_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cand_q      <= '0;
            wait_q      <= '0;
            pv_q        <= '0;
            npv_q       <= '0;
            dsss_q      <= '0;
            rlss_q      <= '0;
            repair_ok_q <= 1'b0;
            sol_dsss_q  <= '0;
            sol_rlss_q  <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            wait_q      <= wait_d;
            pv_q        <= pv_d;
            npv_q       <= npv_d;
            dsss_q      <= dsss_d;
            rlss_q      <= rlss_d;
            repair_ok_q <= repair_ok_d;
            sol_dsss_q  <= sol_dsss_d;
            sol_rlss_q  <= sol_rlss_d;
        end
    end

    assign dsss_o      = dsss_q;
    assign rlss_o      = rlss_q;
    assign busy_o      = (state_q == S_SCAN) || (state_q == S_APPLY) || (state_q == S_CHECK);
    assign done_o      = (state_q == S_DONE);
    assign repair_ok_o = repair_ok_q;
    assign sol_dsss_o  = sol_dsss_q;
    assign sol_rlss_o  = sol_rlss_q;

endmodule

// File: tb/tb_spare_allocation_scheduler.sv
// Bench for spare_allocation_scheduler: a cycle timeline is derived from the
// search rules for every run and compared against the DUT each cycle.
module tb_spare_allocation_scheduler;

    localparam int P = 8;
    localparam int N = 30;
    localparam int R = 4;
    localparam int C = 4;
    localparam int L = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic [P-1:0] pivot_valid_i = '0;
    logic [N-1:0] np_valid_i = '0;
    logic [N-1:0] np_cover_i;
    logic [P-1:0] dsss_o, sol_dsss_o;
    logic [R-1:0] rlss_o, sol_rlss_o;
    logic         busy_o, done_o, repair_ok_o;

    int total = 0;
    int passed = 0;

    // Analyzer stand-in: one cycle after dsss changes, it reports cov_hit
    // for the target assignment and cov_miss for every other one.
    logic [P-1:0] cov_target = '0;
    logic [N-1:0] cov_hit = '0;
    logic [N-1:0] cov_miss = '0;

    typedef struct {
        bit           busy;
        bit           done;
        bit           chk_d;
        logic [P-1:0] dsss;
        logic [R-1:0] rlss;
        bit           chk_r;
        bit           rok;
        logic [P-1:0] sd;
        logic [R-1:0] sr;
    } ent_t;

    ent_t         exp_q[$];
    logic [P-1:0] m_sd = '0;
    logic [R-1:0] m_sr = '0;
    bit           m_rok = 1'b0;
    int           m_legal = 0;
    int           last_len = 0;
    int           apply_idx[$];
    int           check_idx[$];

    spare_allocation_scheduler #(
        .PCAM(P), .NPCAM(N), .RSPARE(R), .CSPARE(C), .ANA_LAT(L)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .abort_i(abort_i),
        .pivot_valid_i(pivot_valid_i),
        .np_valid_i(np_valid_i),
        .np_cover_i(np_cover_i),
        .dsss_o(dsss_o),
        .rlss_o(rlss_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .repair_ok_o(repair_ok_o),
        .sol_dsss_o(sol_dsss_o),
        .sol_rlss_o(sol_rlss_o)
    );

    always #5 clk = ~clk;

    initial np_cover_i = '0;
    always @(posedge clk) np_cover_i <= (dsss_o == cov_target) ? cov_hit : cov_miss;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_legal(input int c, input logic [P-1:0] pv);
        logic [P-1:0] cv;
        int nr;
        cv = P'(c);
        nr = $countones(cv);
        return ((cv & ~pv) == '0) && (nr <= R) && (($countones(pv) - nr) <= C);
    endfunction

    function automatic logic [R-1:0] m_rlss(input int c);
        logic [P-1:0] cv;
        cv = P'(c);
        return R'((1 << $countones(cv)) - 1);
    endfunction

    function automatic bit m_covers(input int c, input logic [N-1:0] npv);
        logic [N-1:0] v;
        v = (P'(c) == cov_target) ? cov_hit : cov_miss;
        return (v & npv) == npv;
    endfunction

    task automatic push(input bit busy, input bit done, input bit cd,
                        input logic [P-1:0] d, input logic [R-1:0] r, input bit cr);
        ent_t e;
        e.busy = busy; e.done = done; e.chk_d = cd; e.dsss = d; e.rlss = r;
        e.chk_r = cr; e.rok = m_rok; e.sd = m_sd; e.sr = m_sr;
        exp_q.push_back(e);
    endtask

    // Timeline of a search started in cycle 0; exp_q[i] describes cycle i+1.
    task automatic build(input logic [P-1:0] pv, input logic [N-1:0] npv);
        m_legal = 0;
        apply_idx.delete();
        check_idx.delete();
        for (int c = 0; c < (1 << P); c++) begin
            push(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
            if (m_is_legal(c, pv)) begin
                m_legal++;
                apply_idx.push_back(exp_q.size() + 1);
                for (int w = 0; w < L; w++) push(1'b1, 1'b0, 1'b1, P'(c), m_rlss(c), 1'b0);
                check_idx.push_back(exp_q.size() + 1);
                push(1'b1, 1'b0, 1'b1, P'(c), m_rlss(c), 1'b0);
                if (m_covers(c, npv)) begin
                    m_sd = P'(c);
                    m_sr = m_rlss(c);
                    m_rok = 1'b1;
                    push(1'b0, 1'b1, 1'b1, '0, '0, 1'b1);
                    push(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
                    return;
                end
            end
        end
        m_rok = 1'b0;
        push(1'b0, 1'b1, 1'b1, '0, '0, 1'b1);
        push(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        ent_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", 64'(busy_o), 64'(e.busy));
            chk("done", 64'(done_o), 64'(e.done));
            chk("sol_dsss", 64'(sol_dsss_o), 64'(e.sd));
            chk("sol_rlss", 64'(sol_rlss_o), 64'(e.sr));
            if (e.chk_d) begin
                chk("dsss", 64'(dsss_o), 64'(e.dsss));
                chk("rlss", 64'(rlss_o), 64'(e.rlss));
            end
            if (e.chk_r) chk("repair_ok", 64'(repair_ok_o), 64'(e.rok));
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_dsss"}, 64'(dsss_o), 64'(0));
        chk({tag, "_rlss"}, 64'(rlss_o), 64'(0));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_done"}, 64'(done_o), 64'(0));
        chk({tag, "_repair_ok"}, 64'(repair_ok_o), 64'(0));
        chk({tag, "_sol_dsss"}, 64'(sol_dsss_o), 64'(0));
        chk({tag, "_sol_rlss"}, 64'(sol_rlss_o), 64'(0));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    endtask

    // One search. abort_cand / rst_cand select the APPLY / CHECK cycle of the
    // n-th legal candidate for an abort or reset; dup_at pulses start while busy.
    task automatic run(input logic [P-1:0] pv, input logic [N-1:0] npv,
                       input int abort_cand, input int rst_cand, input int dup_at);
        logic [P-1:0] s_sd;
        logic [R-1:0] s_sr;
        bit           s_rok;
        int           k;
        @(negedge clk);
        #1;
        pivot_valid_i = pv;
        np_valid_i = npv;
        start_i = 1'b1;
        s_sd = m_sd; s_sr = m_sr; s_rok = m_rok;
        build(pv, npv);
        last_len = exp_q.size();
        k = 0;
        if (abort_cand > 0 && apply_idx.size() >= abort_cand) begin
            k = apply_idx[abort_cand-1];
            while (exp_q.size() > k) void'(exp_q.pop_back());
            m_sd = s_sd; m_sr = s_sr; m_rok = s_rok;
            repeat (3) push(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        pivot_valid_i = P'($urandom);
        np_valid_i = N'($urandom);
        if (k > 0) begin
            repeat (k - 1) @(posedge clk);
            #1;
            abort_i = 1'b1;
            @(posedge clk);
            #1;
            abort_i = 1'b0;
        end
        if (dup_at > 0) begin
            repeat (dup_at - 1) @(posedge clk);
            #1;
            pivot_valid_i = P'($urandom);
            start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        if (rst_cand > 0 && check_idx.size() >= rst_cand) begin
            repeat (check_idx[rst_cand-1] - 1) @(posedge clk);
            #1;
            @(negedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check_zero("reset_mid_check");
            exp_q.delete();
            m_sd = '0; m_sr = '0; m_rok = 1'b0;
            @(negedge clk);
            #1;
            rst_n = 1'b1;
            repeat (2) push(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
        end
        wait_drain();
    endtask

    initial begin
        logic [N-1:0] all_np;
        logic [P-1:0] rpv;
        all_np = '1;

        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Empty pivot and non-pivot sets: first candidate succeeds, done at cycle 4.
        cov_target = '0; cov_hit = '0; cov_miss = '0;
        run(8'h00, '0, 0, 0, 0);
        chk("t1_timeline_len", 64'(last_len), 64'(5));
        chk("t1_sol_dsss", 64'(sol_dsss_o), 64'(8'h00));
        chk("t1_repair_ok", 64'(repair_ok_o), 64'(1));

        // Only dsss=05 covers everything.
        cov_target = 8'h05; cov_hit = '1; cov_miss = N'($urandom) & 30'h3FFF_FFFE;
        run(8'h0F, all_np, 0, 0, 0);
        chk("t2_sol_dsss", 64'(sol_dsss_o), 64'(8'h05));
        chk("t2_sol_rlss", 64'(sol_rlss_o), 64'(4'b0011));
        chk("t2_repair_ok", 64'(repair_ok_o), 64'(1));

        // Full pivot set, nothing ever covers: exhaustive search fails.
        cov_target = '0; cov_hit = '0; cov_miss = '0;
        run(8'hFF, all_np, 0, 0, 0);
        chk("t3_legal_count", 64'(m_legal), 64'(70));
        chk("t3_repair_ok", 64'(repair_ok_o), 64'(0));

        // Restore a success, then abort during APPLY of the third candidate.
        cov_target = 8'h05; cov_hit = '1; cov_miss = '0;
        run(8'h0F, all_np, 0, 0, 0);
        cov_target = 8'hF0; cov_hit = '0; cov_miss = '0;
        run(8'h0F, all_np, 3, 0, 0);
        chk("t4_sol_kept", 64'(sol_dsss_o), 64'(8'h05));
        chk("t4_busy_after_abort", 64'(busy_o), 64'(0));

        // Single valid non-pivot entry covered only by dsss=03; restarts at cand 0.
        cov_target = 8'h03; cov_hit = 30'h1; cov_miss = '0;
        run(8'h0F, 30'h1, 0, 0, 0);
        chk("t5_sol_dsss", 64'(sol_dsss_o), 64'(8'h03));
        chk("t5_sol_rlss", 64'(sol_rlss_o), 64'(4'b0011));

        // Start while busy is ignored.
        cov_target = 8'h06; cov_hit = '1; cov_miss = '0;
        run(8'h0F, all_np, 0, 0, 3);
        chk("t6_sol_dsss", 64'(sol_dsss_o), 64'(8'h06));

        // Reset during the CHECK of the second candidate.
        cov_target = 8'hF0; cov_hit = '0; cov_miss = '0;
        run(8'h0F, all_np, 0, 2, 0);

        // start and abort together in IDLE: nothing happens.
        @(negedge clk);
        #1;
        pivot_valid_i = 8'h0F;
        start_i = 1'b1;
        abort_i = 1'b1;
        repeat (3) push(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        wait_drain();

        // Randomized searches.
        for (int n = 0; n < 20; n++) begin
            rpv = P'($urandom) & P'($urandom_range(0, 255));
            cov_target = P'($urandom) & rpv;
            cov_hit = ($urandom_range(0, 1) == 1) ? '1 : N'($urandom);
            cov_miss = N'($urandom) & N'($urandom);
            case ($urandom_range(0, 3))
                0:       run(rpv, '0, 0, 0, 0);
                1:       run(rpv, all_np, 0, 0, 0);
                default: run(rpv, N'($urandom) & N'($urandom) & N'($urandom), 0, 0, 0);
            endcase
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
